// File: rtl/mmio_console_pkg.sv
// Shared constants and types for the MMIO console: register addresses,
// UART state encoding, STATUS bit positions and the read-size mask helper.
package mmio_pkg;

    localparam logic [63:0] ADDR_DEBUG  = 64'hFFFF_FFFF_FFFF_FFF0;
    localparam logic [63:0] ADDR_HALT   = 64'hFFFF_FFFF_FFFF_FFF8;
    localparam logic [63:0] ADDR_TXDATA = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam logic [63:0] ADDR_STATUS = 64'hFFFF_FFFF_FFFF_FFE8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int STAT_EMPTY     = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_BUSY      = 2;
    localparam int STAT_HALT      = 3;
    localparam int STAT_COUNT_LSB = 8;

    // Narrow STATUS reads to the requested access width (byte/half/word/dword).
    function automatic logic [63:0] size_mask(input logic [1:0] size);
        logic [63:0] mask;
        case (size)
            2'd0:    mask = 64'h0000_0000_0000_00FF;
            2'd1:    mask = 64'h0000_0000_0000_FFFF;
            2'd2:    mask = 64'h0000_0000_FFFF_FFFF;
            default: mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/mmio_console_if.sv
// CPU data-port bus as seen by the MMIO console: address, write/read
// requests and the combinational handshake returned by the peripheral.
interface mmio_console_if;
    logic [63:0] data_address;
    logic [1:0]  data_size;
    logic [63:0] output_data;
    logic        output_data_request;
    logic        output_data_complete;
    logic        input_data_request;
    logic [63:0] input_data;
    logic        input_data_valid;
    logic        selected;

    modport master (
        output data_address, data_size, output_data, output_data_request, input_data_request,
        input  output_data_complete, input_data, input_data_valid, selected
    );

    modport slave (
        input  data_address, data_size, output_data, output_data_request, input_data_request,
        output output_data_complete, input_data, input_data_valid, selected
    );
endinterface

// File: rtl/mmio_console_sync_fifo.sv
// Single-clock show-ahead FIFO; full is registered so a same-cycle pop
// never unblocks a push at a full FIFO.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic [AW:0]      count_nxt_s;
    logic             full_r;
    logic             empty_s;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty_s   = (count_r == CNT_ZERO);
    assign do_push_s = push & ~full_r;
    assign do_pop_s  = pop & ~empty_s;

    // Next occupancy from the accepted push/pop pair.
    always_comb begin
        count_nxt_s = count_r;
        if (do_push_s & ~do_pop_s) begin
            count_nxt_s = count_r + CNT_ONE;
        end else if (do_pop_s & ~do_push_s) begin
            count_nxt_s = count_r - CNT_ONE;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Storage array; contents are don't-care once pointers are reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers, occupancy and the registered full flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= CNT_ZERO;
            full_r   <= 1'b0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CNT_FULL);
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign full  = full_r;
    assign empty = empty_s;
    assign count = count_r;

endmodule

// File: rtl/mmio_console.sv
// MMIO console: decodes the top-of-memory register window, queues TXDATA
// bytes into a FIFO and shifts them out as 8N1 UART; latches HALT/DEBUG.
module mmio_console
    import mmio_pkg::*;
#(
    parameter int FIFO_DEPTH   = 16,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              phi2,
    input  logic              rst,
    mmio_console_if.slave     bus,
    output logic              tx,
    output logic              halt,
    output logic [63:0]       halt_code,
    output logic [63:0]       debug_value,
    output logic              debug_strobe
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_ONE  = BW'(1);

    logic          hit_debug_s, hit_halt_s, hit_tx_s, hit_status_s;
    logic          selected_s, complete_s, valid_s;
    logic          wr_tx_s, wr_halt_s, wr_debug_s;
    logic          fifo_full_s, fifo_empty_s, pop_s, busy_s, baud_last_s;
    logic [7:0]    fifo_rdata_s;
    logic [CW-1:0] fifo_count_s;
    logic [7:0]    count8_s;
    logic [63:0]   status_s;
    logic [63:0]   rdata_s;

    uart_state_t   state_r;
    logic [BW-1:0] baud_r;
    logic [2:0]    bit_r;
    logic [7:0]    shift_r;
    logic          tx_r;
    logic          halt_r;
    logic [63:0]   halt_code_r;
    logic [63:0]   debug_value_r;
    logic          debug_strobe_r;

    assign hit_debug_s  = (bus.data_address == ADDR_DEBUG);
    assign hit_halt_s   = (bus.data_address == ADDR_HALT);
    assign hit_tx_s     = (bus.data_address == ADDR_TXDATA);
    assign hit_status_s = (bus.data_address == ADDR_STATUS);
    assign selected_s   = hit_debug_s | hit_halt_s | hit_tx_s | hit_status_s;

    // Only a TXDATA write into a full FIFO is refused; the CPU simply retries.
    assign complete_s = selected_s & bus.output_data_request & ~(hit_tx_s & fifo_full_s);
    assign valid_s    = selected_s & bus.input_data_request;
    assign wr_tx_s    = complete_s & hit_tx_s;
    assign wr_halt_s  = complete_s & hit_halt_s;
    assign wr_debug_s = complete_s & hit_debug_s;

    assign busy_s      = (state_r != IDLE);
    assign baud_last_s = (baud_r == BAUD_LAST);
    assign pop_s       = ~fifo_empty_s & ((state_r == IDLE) | ((state_r == STOP) & baud_last_s));

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (phi2),
        .rst   (rst),
        .push  (wr_tx_s),
        .wdata (bus.output_data[7:0]),
        .pop   (pop_s),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    assign count8_s = 8'(fifo_count_s);

    // STATUS image and read-data mux; write-only registers read as zero.
    always_comb begin
        status_s                 = 64'h0;
        status_s[STAT_COUNT_LSB +: 8] = count8_s;
        status_s[STAT_HALT]      = halt_r;
        status_s[STAT_BUSY]      = busy_s;
        status_s[STAT_FULL]      = fifo_full_s;
        status_s[STAT_EMPTY]     = fifo_empty_s;
        if (valid_s & hit_status_s) begin
            rdata_s = status_s & size_mask(bus.data_size);
        end else begin
            rdata_s = 64'h0;
        end
    end

    assign bus.selected             = selected_s;
    assign bus.output_data_complete = complete_s;
    assign bus.input_data_valid     = valid_s;
    assign bus.input_data           = rdata_s;

    // HALT / DEBUG register bank.
    always_ff @(posedge phi2 or posedge rst) begin
        if (rst) begin
            halt_r         <= 1'b0;
            halt_code_r    <= 64'h0;
            debug_value_r  <= 64'h0;
            debug_strobe_r <= 1'b0;
        end else begin
            if (wr_halt_s) begin
                halt_r      <= 1'b1;
                halt_code_r <= bus.output_data;
            end
            if (wr_debug_s) begin
                debug_value_r <= bus.output_data;
            end
            debug_strobe_r <= wr_debug_s;
        end
    end

    // UART transmitter; tx changes on the same edge as each state/bit step.
    always_ff @(posedge phi2 or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            baud_r  <= {BW{1'b0}};
            bit_r   <= 3'd0;
            shift_r <= 8'h00;
            tx_r    <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    baud_r <= {BW{1'b0}};
                    if (pop_s) begin
                        state_r <= START;
                        shift_r <= fifo_rdata_s;
                        tx_r    <= 1'b0;
                    end else begin
                        tx_r    <= 1'b1;
                    end
                end
                START: begin
                    if (baud_last_s) begin
                        baud_r  <= {BW{1'b0}};
                        state_r <= DATA;
                        bit_r   <= 3'd0;
                        tx_r    <= shift_r[0];
                        shift_r <= {1'b0, shift_r[7:1]};
                    end else begin
                        baud_r  <= baud_r + BAUD_ONE;
                    end
                end
                DATA: begin
                    if (baud_last_s) begin
                        baud_r <= {BW{1'b0}};
                        if (bit_r == 3'd7) begin
                            state_r <= STOP;
                            tx_r    <= 1'b1;
                        end else begin
                            bit_r   <= bit_r + 3'd1;
                            tx_r    <= shift_r[0];
                            shift_r <= {1'b0, shift_r[7:1]};
                        end
                    end else begin
                        baud_r <= baud_r + BAUD_ONE;
                    end
                end
                STOP: begin
                    if (baud_last_s) begin
                        baud_r <= {BW{1'b0}};
                        // Back-to-back frames: go straight to the next start bit.
                        if (pop_s) begin
                            state_r <= START;
                            shift_r <= fifo_rdata_s;
                            tx_r    <= 1'b0;
                        end else begin
                            state_r <= IDLE;
                            tx_r    <= 1'b1;
                        end
                    end else begin
                        baud_r <= baud_r + BAUD_ONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    baud_r  <= {BW{1'b0}};
                    tx_r    <= 1'b1;
                end
            endcase
        end
    end

    assign tx           = tx_r;
    assign halt         = halt_r;
    assign halt_code    = halt_code_r;
    assign debug_value  = debug_value_r;
    assign debug_strobe = debug_strobe_r;

endmodule

// File: tb/tb_mmio_console.sv
// Directed bench for mmio_console (FIFO_DEPTH=4, CLKS_PER_BIT=4) with
// hand-computed expectations checked by immediate assertions.
module tb_mmio_console;
    import mmio_pkg::*;

    localparam int DEPTH = 4;
    localparam int CPB   = 4;

    logic        phi2 = 1'b0;
    logic        rst  = 1'b1;
    logic        tx, halt, debug_strobe;
    logic [63:0] halt_code, debug_value;
    int          checks = 0;
    int          errors = 0;
    logic        rec_en = 1'b0;
    logic        txlog[$];

    mmio_console_if bus();

    mmio_console #(.FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
        .phi2         (phi2),
        .rst          (rst),
        .bus          (bus),
        .tx           (tx),
        .halt         (halt),
        .halt_code    (halt_code),
        .debug_value  (debug_value),
        .debug_strobe (debug_strobe)
    );

    always #5 phi2 = ~phi2;

    always @(negedge phi2) begin
        if (rec_en) txlog.push_back(tx);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag, input logic [63:0] exp);
        bus.data_address       = ADDR_STATUS;
        bus.input_data_request = 1'b1;
        #1;
        check({tag, "_valid"}, {63'd0, bus.input_data_valid}, 64'd1);
        check(tag, bus.input_data, exp);
        bus.input_data_request = 1'b0;
    endtask

    // Present one write, report whether it was accepted, end just after the edge.
    task automatic write_once(input logic [63:0] addr, input logic [63:0] data, output logic acc);
        bus.data_address        = addr;
        bus.output_data         = data;
        bus.output_data_request = 1'b1;
        #1;
        acc = bus.output_data_complete;
        @(posedge phi2); #1;
        bus.output_data_request = 1'b0;
    endtask

    task automatic write_retry(input logic [63:0] addr, input logic [63:0] data, output int stalls);
        logic acc;
        stalls = 0;
        acc    = 1'b0;
        while (!acc && stalls < 200) begin
            write_once(addr, data, acc);
            if (!acc) stalls++;
        end
    endtask

    initial begin
        logic        acc;
        logic [63:0] rd;
        logic [7:0]  bytes [6];
        logic        exp_bit;
        int          stalls, mism, s0, idx, waited;
        logic [7:0]  b41;

        bus.data_address        = 64'h0;
        bus.data_size           = 2'd3;
        bus.output_data         = 64'h0;
        bus.output_data_request = 1'b0;
        bus.input_data_request  = 1'b0;

        // Reset state, including combinational STATUS read during reset
        #7;
        check("rst_tx", {63'd0, tx}, 64'd1);
        check("rst_halt", {63'd0, halt}, 64'd0);
        check("rst_halt_code", halt_code, 64'h0);
        check("rst_debug_value", debug_value, 64'h0);
        check("rst_debug_strobe", {63'd0, debug_strobe}, 64'd0);
        check_status("rst_status", 64'h1);
        @(negedge phi2);
        rst = 1'b0;
        @(posedge phi2); #1;

        // Single byte 0x41: frame 0,1,0,0,0,0,0,1,0,1 at 4 clocks per bit
        write_once(ADDR_TXDATA, 64'h41, acc);
        check("tx41_accept", {63'd0, acc}, 64'd1);
        check("tx41_idle_at_push", {63'd0, tx}, 64'd1);
        b41 = 8'h41;
        for (int k = 0; k < 10; k++) begin
            exp_bit = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b41[k-1];
            mism = 0;
            for (int s = 0; s < CPB; s++) begin
                @(posedge phi2); #1;
                if (tx !== exp_bit) mism++;
            end
            check($sformatf("tx41_bit%0d", k), 64'(mism), 64'd0);
        end
        check_status("tx41_busy_last", 64'h5);
        @(posedge phi2); #1;
        check_status("tx41_idle_after", 64'h1);

        // Six back-to-back writes into a 4-deep FIFO
        bytes[0] = 8'hA5; bytes[1] = 8'h3C; bytes[2] = 8'h01;
        bytes[3] = 8'hFF; bytes[4] = 8'h80; bytes[5] = 8'h5A;
        rec_en = 1'b1;
        for (int j = 0; j < 6; j++) begin
            write_retry(ADDR_TXDATA, {56'h0, bytes[j]}, stalls);
            check($sformatf("burst_stalls%0d", j), 64'(stalls), (j == 5) ? 64'd37 : 64'd0);
        end
        waited = 0;
        rd = 64'h0;
        while (rd !== 64'h1 && waited < 400) begin
            @(posedge phi2); #1;
            bus.data_address = ADDR_STATUS; bus.input_data_request = 1'b1;
            #1; rd = bus.input_data; bus.input_data_request = 1'b0;
            waited++;
        end
        check("burst_drained", rd, 64'h1);
        @(posedge phi2); #1;
        rec_en = 1'b0;
        s0 = -1;
        for (int i = 0; i < txlog.size(); i++) begin
            if (s0 < 0 && txlog[i] === 1'b0) s0 = i;
        end
        check("burst_found_start", {63'd0, (s0 >= 0)}, 64'd1);
        for (int j = 0; j < 6; j++) begin
            mism = 0;
            for (int k = 0; k < 10; k++) begin
                exp_bit = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : bytes[j][k-1];
                for (int s = 0; s < CPB; s++) begin
                    idx = s0 + 40*j + CPB*k + s;
                    if (s0 < 0 || idx >= txlog.size() || txlog[idx] !== exp_bit) mism++;
                end
            end
            check($sformatf("burst_frame%0d", j), 64'(mism), 64'd0);
        end

        // HALT: sticky flag, overwritable code, STATUS bit 3
        check("halt_before", {63'd0, halt}, 64'd0);
        write_once(ADDR_HALT, 64'h2A, acc);
        check("halt_accept", {63'd0, acc}, 64'd1);
        check("halt_set", {63'd0, halt}, 64'd1);
        check("halt_code_2a", halt_code, 64'h2A);
        check_status("halt_status", 64'h9);
        write_once(ADDR_HALT, 64'h7, acc);
        check("halt_still", {63'd0, halt}, 64'd1);
        check("halt_code_7", halt_code, 64'h7);

        // Write-only register reads as zero; STATUS write is accepted and ignored
        bus.data_address = ADDR_HALT; bus.input_data_request = 1'b1;
        #1;
        check("rd_halt_valid", {63'd0, bus.input_data_valid}, 64'd1);
        check("rd_halt_zero", bus.input_data, 64'h0);
        bus.input_data_request = 1'b0;
        write_once(ADDR_STATUS, 64'hFFFF, acc);
        check("wr_status_accept", {63'd0, acc}, 64'd1);
        check_status("wr_status_noeffect", 64'h9);

        // DEBUG of -5 with one-cycle strobe
        write_once(ADDR_DEBUG, 64'hFFFF_FFFF_FFFF_FFFB, acc);
        check("debug_accept", {63'd0, acc}, 64'd1);
        check("debug_value", debug_value, 64'hFFFF_FFFF_FFFF_FFFB);
        check("debug_strobe_hi", {63'd0, debug_strobe}, 64'd1);
        @(posedge phi2); #1;
        check("debug_strobe_lo", {63'd0, debug_strobe}, 64'd0);

        // Out-of-window access
        bus.data_address = 64'h1000; bus.output_data = 64'h1234;
        bus.output_data_request = 1'b1; bus.input_data_request = 1'b1;
        #1;
        check("oow_selected", {63'd0, bus.selected}, 64'd0);
        check("oow_complete", {63'd0, bus.output_data_complete}, 64'd0);
        check("oow_valid", {63'd0, bus.input_data_valid}, 64'd0);
        check("oow_data", bus.input_data, 64'h0);
        @(posedge phi2); #1;
        bus.output_data_request = 1'b0; bus.input_data_request = 1'b0;
        check("oow_halt_code", halt_code, 64'h7);
        check("oow_debug", debug_value, 64'hFFFF_FFFF_FFFF_FFFB);
        check_status("oow_status", 64'h9);

        // TXDATA after halt still accepted; reset mid-DATA (bit1 of 0x55 is 0)
        write_once(ADDR_TXDATA, 64'h55, acc);
        check("post_halt_tx_accept", {63'd0, acc}, 64'd1);
        repeat (10) @(posedge phi2);
        #1;
        check("mid_data_tx", {63'd0, tx}, 64'd0);
        check_status("mid_data_status", 64'hD);
        rst = 1'b1;
        #1;
        check("rst_mid_tx", {63'd0, tx}, 64'd1);
        check("rst_mid_halt", {63'd0, halt}, 64'd0);
        check("rst_mid_halt_code", halt_code, 64'h0);
        check("rst_mid_debug", debug_value, 64'h0);
        @(negedge phi2);
        rst = 1'b0;
        @(posedge phi2); #1;
        check_status("rst_mid_status", 64'h1);
        repeat (8) @(posedge phi2);
        #1;
        check("rst_mid_tx_idle", {63'd0, tx}, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
